// File: rtl/ap_ctrl_pkg.sv
// Shared defaults and latency helpers for the ap_ctrl_chain initiator.
package ap_ctrl_pkg;

  localparam int IN_W_DEF     = 16;
  localparam int OUT_W_DEF    = 16;
  localparam int LAT_W_DEF    = 16;
  localparam int TS_DEPTH_DEF = 4;
  localparam int CNT_W_DEF    = 32;

  typedef logic [LAT_W_DEF-1:0] lat_t;

  // Modular difference; wraps cleanly when the cycle counter has rolled over.
  function automatic lat_t lat_diff(input lat_t now, input lat_t past);
    return now - past;
  endfunction

endpackage

// File: rtl/ap_ctrl_ts_fifo.sv
// Start-timestamp FIFO: one entry per transaction accepted by the core.
module ap_ctrl_ts_fifo #(
  parameter int LAT_W    = 16,
  parameter int TS_DEPTH = 4
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [LAT_W-1:0] din,
  output logic [LAT_W-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(TS_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TS_DEPTH);

  logic [LAT_W-1:0] mem [TS_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < TS_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_chain initiator: streams inputs into an HLS core and returns
// each result tagged with its ap_ready-to-ap_done latency in cycles.
module ap_ctrl_driver
  import ap_ctrl_pkg::*;
#(
  parameter int IN_W     = IN_W_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  parameter int LAT_W    = LAT_W_DEF,
  parameter int TS_DEPTH = TS_DEPTH_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [LAT_W-1:0] m_latency,
  output logic             core_ap_start,
  input  logic             core_ap_ready,
  input  logic             core_ap_done,
  output logic             core_ap_continue,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic             err_protocol
);

  logic [LAT_W-1:0] cyc;
  logic [LAT_W-1:0] ts_head;
  logic [LAT_W-1:0] lat_raw;
  logic [LAT_W-1:0] lat_cur;
  logic             ts_full;
  logic             ts_empty;
  logic             ts_pop;
  logic             start_pending;
  logic             complete;

  // Start is masked during reset so the core never sees a stray request.
  assign core_ap_start    = ap_rst_n & (start_pending | (s_valid & enable & ~ts_full));
  assign s_ready          = core_ap_start & core_ap_ready;
  assign core_ap_continue = ~m_valid | m_ready;
  assign core_in          = s_data;
  assign complete         = core_ap_done & core_ap_continue;
  assign ts_pop           = complete & ~ts_empty;
  assign busy             = ~ts_empty | m_valid;

  if (LAT_W == LAT_W_DEF) begin : g_pkg_diff
    assign lat_raw = lat_diff(cyc, ts_head);
  end else begin : g_wide_diff
    assign lat_raw = cyc - ts_head;
  end

  // A done with nothing in flight has no start timestamp to measure against.
  assign lat_cur = ts_empty ? '0 : lat_raw;

  ap_ctrl_ts_fifo #(
    .LAT_W    (LAT_W),
    .TS_DEPTH (TS_DEPTH)
  ) u_ts_fifo (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .push     (s_ready),
    .pop      (ts_pop),
    .din      (cyc),
    .head     (ts_head),
    .full     (ts_full),
    .empty    (ts_empty)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cyc           <= '0;
      start_pending <= 1'b0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_latency     <= '0;
      txn_count     <= '0;
      err_protocol  <= 1'b0;
    end else begin
      cyc <= cyc + 1'b1;

      // ap_start must stay high until the core takes it, even if enable drops.
      if (core_ap_ready)      start_pending <= 1'b0;
      else if (core_ap_start) start_pending <= 1'b1;

      if (complete) begin
        m_valid   <= 1'b1;
        m_data    <= core_out;
        m_latency <= lat_cur;
        txn_count <= txn_count + 1'b1;
        if (ts_empty) err_protocol <= 1'b1;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ap_ctrl_driver.sv
// Bench for ap_ctrl_driver with a behavioural pipelined ap_ctrl_chain core.
`timescale 1ns/1ps
module tb_ap_ctrl_driver;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        enable;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [15:0] m_latency;
  logic        core_ap_start;
  logic        core_ap_ready;
  logic        core_ap_done;
  logic        core_ap_continue;
  logic [15:0] core_in;
  logic [15:0] core_out;
  logic        busy;
  logic [31:0] txn_count;
  logic        err_protocol;

  ap_ctrl_driver #(
    .IN_W(16), .OUT_W(16), .LAT_W(16), .TS_DEPTH(4), .CNT_W(32)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_latency(m_latency),
    .core_ap_start(core_ap_start), .core_ap_ready(core_ap_ready),
    .core_ap_done(core_ap_done), .core_ap_continue(core_ap_continue),
    .core_in(core_in), .core_out(core_out),
    .busy(busy), .txn_count(txn_count), .err_protocol(err_protocol)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct { logic [15:0] d; int lat; } exp_t;
  typedef struct { logic [15:0] d; int due; } job_t;

  exp_t sb[$];
  job_t cq[$];
  int   acc_edges[$];
  int   cmp_edges[$];

  int n_chk = 0;
  int n_fail = 0;
  int core_lat = 1;
  int rdy_dly = 0;
  int max_inflight = 0;
  int sready_cnt = 0;
  bit spur_req = 1'b0;
  logic [15:0] spur_data = 16'h0;

  function automatic logic [15:0] core_fn(input logic [15:0] x);
    return x ^ 16'h129F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Core model: accepts on start&ready, raises done core_lat edges later,
  // holds done while continue is low, in-order completion.
  initial begin : core_model
    bit acc, cmp, st, rst_s, spur_on;
    logic [15:0] ind;
    int ccount, wait_n;
    ccount = 0; wait_n = 0; spur_on = 1'b0;
    core_ap_ready = 1'b0; core_ap_done = 1'b0; core_out = 16'h0;
    forever begin
      @(negedge ap_clk);
      rst_s = ap_rst_n;
      st    = core_ap_start;
      acc   = ap_rst_n && core_ap_start && core_ap_ready;
      cmp   = ap_rst_n && core_ap_done && core_ap_continue;
      ind   = core_in;
      @(posedge ap_clk);
      #1;
      ccount++;
      if (!rst_s) begin
        cq.delete();
        wait_n  = 0;
        spur_on = 1'b0;
      end else begin
        if (cmp) begin
          if (spur_on) spur_on = 1'b0;
          else if (cq.size() > 0) begin
            void'(cq.pop_front());
            cmp_edges.push_back(ccount);
          end
        end
        if (acc) begin
          cq.push_back('{ind, ccount + core_lat});
          acc_edges.push_back(ccount);
          wait_n = 0;
        end else if (st) begin
          wait_n++;
        end
        if (spur_req) begin
          spur_on  = 1'b1;
          spur_req = 1'b0;
        end
        if (cq.size() > max_inflight) max_inflight = cq.size();
      end
      core_ap_ready = (wait_n >= rdy_dly);
      if (spur_on) begin
        core_ap_done = 1'b1;
        core_out     = spur_data;
      end else if (cq.size() > 0 && cq[0].due <= ccount + 1) begin
        core_ap_done = 1'b1;
        core_out     = core_fn(cq[0].d);
      end else begin
        core_ap_done = 1'b0;
        core_out     = 16'h0;
      end
    end
  end

  // Output monitor: every m_valid&m_ready transfer is checked against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && s_ready) sready_cnt++;
      if (ap_rst_n && m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got m_data=%0h expected no result", m_data);
        end else begin
          e = sb.pop_front();
          chk("m_data", 32'(m_data), 32'(e.d));
          if (e.lat >= 0) chk("m_latency", 32'(m_latency), e.lat);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    ap_rst_n = 1'b0;
    s_valid  = 1'b1;
    enable   = 1'b1;
    m_ready  = 1'b1;
    sb.delete();
    @(negedge ap_clk);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_m_latency", 32'(m_latency), 0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_err_protocol", 32'(err_protocol), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_core_ap_start", 32'(core_ap_start), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    @(posedge ap_clk);
    #1;
    s_valid  = 1'b0;
    ap_rst_n = 1'b1;
    acc_edges.delete();
    cmp_edges.delete();
    max_inflight = 0;
    sready_cnt   = 0;
    rdy_dly      = 0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] exp_d, input int exp_lat,
                      output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge ap_clk);
      waits++;
      if (s_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) sb.push_back('{exp_d, exp_lat});
    else fail_now("send_accept");
    @(posedge ap_clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge ap_clk);
      if (sb.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now("drain");
    @(posedge ap_clk);
    #1;
  endtask

  initial begin : stimulus
    int w;
    bit got;
    logic [15:0] d0, d1;
    ap_rst_n = 1'b0;
    enable   = 1'b1;
    s_valid  = 1'b0;
    s_data   = 16'h0;
    m_ready  = 1'b1;

    // 1: single transaction, latency 5
    do_reset();
    core_lat = 5;
    send(16'h1234, 16'h00AB, 5, w);
    drain(200);
    chk("t1_s_ready_pulses", sready_cnt, 1);
    chk("t1_txn_count", txn_count, 1);
    chk("t1_err_protocol", 32'(err_protocol), 0);

    // 2: II=1 latency-3 core, 8 back-to-back inputs
    do_reset();
    core_lat = 3;
    for (int i = 0; i < 8; i++) begin
      d0 = 16'h1000 + 16'(i * 16'h0111);
      send(d0, core_fn(d0), 3, w);
      chk("t2_accept_first_cycle", w, 1);
    end
    drain(200);
    chk("t2_txn_count", txn_count, 8);

    // 3: latency 10 with 4-deep timestamp FIFO, 6 inputs
    do_reset();
    core_lat = 10;
    for (int i = 0; i < 6; i++) begin
      d0 = 16'hA000 + 16'(i);
      send(d0, core_fn(d0), 10, w);
    end
    drain(300);
    chk("t3_max_inflight", max_inflight, 4);
    if (acc_edges.size() == 6 && cmp_edges.size() >= 1) begin
      chk("t3_four_before_done", 32'(acc_edges[3] < cmp_edges[0]), 1);
      chk("t3_fifth_after_pop", acc_edges[4] - cmp_edges[0], 1);
    end else fail_now("t3_accept_count");
    chk("t3_txn_count", txn_count, 6);

    // 4: downstream stall for 7 cycles
    do_reset();
    core_lat = 3;
    m_ready  = 1'b0;
    d0 = 16'h3C3C;
    d1 = 16'h4D4D;
    send(d0, core_fn(d0), 3, w);
    send(d1, core_fn(d1), -1, w);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ap_clk);
      if (m_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("t4_first_result");
    for (int i = 0; i < 7; i++) begin
      @(negedge ap_clk);
      chk("t4_continue_low", 32'(core_ap_continue), 0);
      chk("t4_done_held", 32'(core_ap_done), 1);
      chk("t4_m_data_stable", 32'(m_data), 32'(core_fn(d0)));
    end
    @(posedge ap_clk);
    #1;
    m_ready = 1'b1;
    drain(200);
    chk("t4_txn_count", txn_count, 2);

    // 5: enable drops while ap_start waits for ap_ready
    do_reset();
    core_lat = 4;
    rdy_dly  = 2;
    s_valid  = 1'b1;
    s_data   = 16'hBEEF;
    @(negedge ap_clk);
    chk("t5_start_raised", 32'(core_ap_start), 1);
    chk("t5_not_ready_yet", 32'(s_ready), 0);
    @(posedge ap_clk);
    #1;
    enable = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      chk("t5_start_held", 32'(core_ap_start), 1);
      if (s_ready) begin
        sb.push_back('{core_fn(16'hBEEF), 4});
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now("t5_accept");
    @(posedge ap_clk);
    #1;
    s_data = 16'hCAFE;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("t5_no_new_start", 32'(core_ap_start), 0);
    end
    @(posedge ap_clk);
    #1;
    s_valid = 1'b0;
    drain(200);
    chk("t5_txn_count", txn_count, 1);
    chk("t5_busy_idle", 32'(busy), 0);
    chk("t5_accepts", acc_edges.size(), 1);

    // 6: spurious done, then reset in the middle of a transaction
    do_reset();
    core_lat  = 10;
    spur_data = 16'h5A5A;
    sb.push_back('{16'h5A5A, 0});
    @(negedge ap_clk);
    spur_req = 1'b1;
    drain(100);
    chk("t6_err_set", 32'(err_protocol), 1);
    chk("t6_txn_count", txn_count, 1);
    repeat (5) @(negedge ap_clk);
    chk("t6_err_sticky", 32'(err_protocol), 1);
    @(posedge ap_clk);
    #1;
    send(16'h7777, core_fn(16'h7777), 10, w);
    repeat (3) @(posedge ap_clk);
    #1;
    do_reset();
    repeat (20) @(negedge ap_clk);
    chk("t6_post_rst_m_valid", 32'(m_valid), 0);
    chk("t6_post_rst_busy", 32'(busy), 0);
    chk("t6_post_rst_txn_count", txn_count, 0);
    chk("t6_post_rst_err", 32'(err_protocol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_driver.md
Name: ap_ctrl_driver

Overview:
- Synthesizable initiator for the HLS ap_ctrl_chain block-level handshake (ap_start/ap_ready/ap_done/ap_continue).
- Drives one myproject-style core from a valid/ready input stream and returns core results on a valid/ready output stream.
- Tags each result with its start-to-done latency in cycles, for on-chip and ASIC latency characterisation without the simulation monitors.
- Supports pipelined cores: several transactions may be in flight.

Parameters:
- IN_W, 16, core input vector width (bits).
- OUT_W, 16, core output vector width (bits).
- LAT_W, 16, cycle-counter and latency width.
- TS_DEPTH, 4, maximum in-flight transactions (power of 2, >=2).
- CNT_W, 32, transaction counter width.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- enable  in  1  permit new starts
- s_valid  in  1  input vector valid
- s_ready  out  1  input vector accepted
- s_data  in  IN_W  input vector
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  OUT_W  core result
- m_latency  out  LAT_W  cycles from ap_start/ap_ready handshake to ap_done
- core_ap_start  out  1  to core
- core_ap_ready  in  1  from core
- core_ap_done  in  1  from core
- core_ap_continue  out  1  to core
- core_in  out  IN_W  to core, equals s_data
- core_out  in  OUT_W  from core, valid when core_ap_done=1
- busy  out  1  any transaction in flight or m_valid
- txn_count  out  CNT_W  completed transactions
- err_protocol  out  1  sticky: ap_done with no transaction in flight

Behaviour:
- Reset values:
  - All registers clear asynchronously on ap_rst_n=0.
  - m_valid=0, m_data=0, m_latency=0, txn_count=0, err_protocol=0, start_pending=0, cycle counter=0, FIFO empty.
  - core_ap_start=0 and s_ready=0 while in reset.
- Free-running cycle counter cyc[LAT_W] increments every cycle and wraps modulo 2^LAT_W.
- Start logic:
  - core_ap_start = start_pending | (s_valid & enable & !ts_full).
  - start_pending is set when core_ap_start=1 and core_ap_ready=0. It clears on core_ap_ready=1.
  - Once asserted, ap_start holds until ap_ready, even if enable drops. Upstream must hold s_valid and s_data stable until s_ready.
- Accept:
  - s_ready = core_ap_start & core_ap_ready (combinational).
  - On accept, push cyc into the timestamp FIFO in the same cycle.
- Continue:
  - core_ap_continue = !m_valid | m_ready. This is output-register free space.
  - The core holds ap_done while ap_continue=0.
- Completion occurs when core_ap_done=1 and core_ap_continue=1. In the same edge:
  - m_data <= core_out; m_latency <= cyc - ts_head (modular); m_valid <= 1.
  - Pop the FIFO; txn_count++ (wraps).
  - The result is visible one cycle after ap_done.
- Output handshake:
  - m_valid clears when m_ready=1 and no completion occurs that cycle.
  - Simultaneous m_ready and completion: m_valid stays 1 with the new data. This gives back-to-back throughput of 1 per cycle.
- Simultaneous push and pop: both occur; occupancy unchanged. Pop of a single-entry FIFO with push in the same cycle is legal.
- ts_full: no new start is raised. A start_pending already raised is legal because the push only happens on ap_ready, and the start gate prevents overflow.
- Protocol error, completion with the FIFO empty:
  - err_protocol <= 1 (sticky until reset).
  - Data is still captured with m_latency=0.
  - No pop; txn_count still increments.
- Latency is exact if the true latency < 2^LAT_W. Otherwise it is reported modulo 2^LAT_W.
- enable=0 mid-operation: in-flight transactions complete normally. busy stays 1 until the FIFO is empty and m_valid=0.
- Reset mid-operation: everything is discarded, with no partial output. The core shares the same reset.

Decomposition:
- Package ap_ctrl_pkg:
  - Default widths.
  - typedef lat_t = logic [LAT_W-1:0].
  - Helper function lat_diff(now, then) returning modular difference.
- Sub-module ap_ctrl_ts_fifo:
  - Synchronous FIFO, width LAT_W, depth TS_DEPTH.
  - Ports: push/pop/head/full/empty.
  - Same clock and async active-low reset.

Test Plan:
1. Single transaction, core model with ready at start and done 5 cycles later, s_data=0x1234, core_out=0x00AB, m_ready=1 -> exactly one s_ready pulse; m_valid 1 cycle after done; m_data=0x00AB, m_latency=5, txn_count=1, err_protocol=0.
2. Pipelined core (II=1, latency 3), 8 back-to-back inputs -> 8 results in order, each m_latency=3, start never deasserted while s_valid=1, txn_count=8.
3. Core latency 10, TS_DEPTH=4, 6 inputs queued -> at most 4 accepts before the first done; the 5th start is raised only after the first pop; all m_latency=10.
4. m_ready=0 for 7 cycles during a result -> core_ap_continue=0, core holds ap_done, m_data stable; after m_ready=1 the next result is captured with no loss.
5. enable dropped in the cycle after ap_start rises with ap_ready=0 -> ap_start held until ap_ready; transaction completes; no further starts.
6. Spurious core_ap_done with FIFO empty -> err_protocol=1 sticky, m_latency=0. Then reset asserted mid-transaction -> all outputs at reset values, err_protocol=0.
